// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD registered read ports (1-cycle latency), two write lanes, pending-write scoreboard.
// No handshakes: every input is sampled each cycle; ren=0 holds rdata/rbusy while writes and scoreboard updates continue.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = $clog2(NREG),
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  ren,
  input  logic [NRD*AW-1:0]     radd,
  input  logic                  wen0,
  input  logic [AW-1:0]         wadd0,
  input  logic [XLEN-1:0]       wdata0,
  input  logic                  wen1,
  input  logic [AW-1:0]         wadd1,
  input  logic [XLEN-1:0]       wdata1,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  output logic [NRD*XLEN-1:0]   rdata,
  output logic [NRD-1:0]        rbusy,
  output logic [NREG-1:0]       busy_vec
);

  localparam bit ZR = (ZERO_REG != 0);
  localparam bit BP = (BYPASS != 0);

  logic [XLEN-1:0]     mem_q [NREG];
  logic [XLEN-1:0]     mem_d [NREG];
  logic [NREG-1:0]     busy_q, busy_d;
  logic [NRD*XLEN-1:0] rdata_q, rdata_d;
  logic [NRD-1:0]      rbusy_q, rbusy_d;

  logic we0, we1, sb_v;

  // With a hardwired zero register, anything aimed at address 0 is simply dropped.
  assign we0  = wen0   && !(ZR && (wadd0   == '0));
  assign we1  = wen1   && !(ZR && (wadd1   == '0));
  assign sb_v = sb_set && !(ZR && (sb_addr == '0));

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      mem_d[r]  = mem_q[r];
      busy_d[r] = busy_q[r];
      if (we0 && (wadd0 == AW'(r))) begin
        mem_d[r]  = wdata0;
        busy_d[r] = 1'b0;
      end
      if (we1 && (wadd1 == AW'(r))) begin
        mem_d[r]  = wdata1;
        busy_d[r] = 1'b0;
      end
      // A new producer issued this cycle is younger than the retiring one.
      if (sb_v && (sb_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end
    end
  end

  always_comb begin
    logic [AW-1:0] ra;
    rdata_d = rdata_q;
    rbusy_d = rbusy_q;
    ra      = '0;
    if (ren) begin
      for (int k = 0; k < NRD; k++) begin
        ra = radd[k*AW +: AW];
        if (ZR && (ra == '0)) begin
          rdata_d[k*XLEN +: XLEN] = '0;
        end else if (BP && we1 && (wadd1 == ra)) begin
          rdata_d[k*XLEN +: XLEN] = wdata1;
        end else if (BP && we0 && (wadd0 == ra)) begin
          rdata_d[k*XLEN +: XLEN] = wdata0;
        end else begin
          rdata_d[k*XLEN +: XLEN] = mem_q[ra];
        end
        rbusy_d[k] = BP ? busy_d[ra] : busy_q[ra];
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mem_q   <= '{default: '0};
      busy_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata    = rdata_q;
  assign rbusy    = rbusy_q;
  assign busy_vec = busy_q;

endmodule
